// File: rtl/isram_boot_pkg.sv
// Shared definitions for the ISRAM boot loader.
//   boot_state_e   : loader FSM states
//   BYTES_PER_WORD : bytes assembled per SRAM word
package isram_boot_pkg;

    typedef enum logic [2:0] {
        ST_START,
        ST_HDR,
        ST_DATA,
        ST_CHK,
        ST_DONE,
        ST_ERROR
    } boot_state_e;

    localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/isram_word_packer.sv
// Assembles little-endian 32-bit words from an accepted byte stream.
//   clk_i, rst_ni   : clock, async active-low reset
//   clr_i           : drop any partial word (used on every FSM state change)
//   byte_valid_i    : a byte is accepted this cycle
//   byte_i          : accepted byte
//   word_valid_o    : this cycle's byte completes a word (combinational pulse)
//   word_o          : completed word, valid with word_valid_o
module isram_word_packer
    import isram_boot_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        clr_i,
    input  logic        byte_valid_i,
    input  logic [7:0]  byte_i,
    output logic        word_valid_o,
    output logic [31:0] word_o
);

    logic [1:0]  cnt_q;
    logic [31:0] word_q;

    // Bytes enter at the top and move down, so the first byte of a word
    // ends up in bits [7:0] once the fourth byte arrives.
    assign word_o       = {byte_i, word_q[31:8]};
    assign word_valid_o = byte_valid_i && (cnt_q == 2'(BYTES_PER_WORD - 1));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q  <= '0;
            word_q <= '0;
        end else if (clr_i) begin
            cnt_q  <= '0;
            word_q <= '0;
        end else if (byte_valid_i) begin
            cnt_q  <= cnt_q + 2'd1;
            word_q <= word_o;
        end
    end

endmodule

// File: rtl/isram_boot_loader.sv
// Boot-time owner of the ISRAM port. Receives an image (N, N words,
// checksum) as a byte stream, writes it to SRAM, verifies the checksum and
// then hands the SRAM port to the AHB bridge and releases CPU reset.
//   HCLK, HRESETn          : clock, async active-low reset
//   BOOTMODE               : 1 = load image, 0 = skip load (sampled in START)
//   RXDATA/RXVALID/RXREADY : image byte stream
//   BUS_SRAM*              : bridge-side SRAM port (used only in DONE)
//   SRAM*                  : ISRAM macro port
//   CPURESETn              : CPU reset, released only in DONE
//   LOAD_DONE, LOAD_ERR    : load status
module isram_boot_loader
    import isram_boot_pkg::*;
#(
    parameter int AW = 16
) (
    input  logic          HCLK,
    input  logic          HRESETn,
    input  logic          BOOTMODE,
    input  logic [7:0]    RXDATA,
    input  logic          RXVALID,
    output logic          RXREADY,
    input  logic [AW-3:0] BUS_SRAMADDR,
    input  logic [3:0]    BUS_SRAMWEN,
    input  logic [31:0]   BUS_SRAMWDATA,
    input  logic          BUS_SRAMCS,
    output logic [AW-3:0] SRAMADDR,
    output logic [3:0]    SRAMWEN,
    output logic [31:0]   SRAMWDATA,
    output logic          SRAMCS,
    output logic          CPURESETn,
    output logic          LOAD_DONE,
    output logic          LOAD_ERR
);

    localparam logic [31:0]   MAX_WORDS = 32'd1 << (AW - 2);
    localparam logic [AW-2:0] IDX_ONE   = 1;

    boot_state_e   state_q, state_d;
    logic [AW-2:0] n_q, n_d;          // one bit wider than the address so N = capacity fits
    logic [AW-2:0] idx_q, idx_d;
    logic [31:0]   sum_q, sum_d;
    logic          wr_cs_q, wr_cs_d;
    logic [3:0]    wr_wen_q, wr_wen_d;
    logic [AW-3:0] wr_addr_q, wr_addr_d;
    logic [31:0]   wr_data_q, wr_data_d;

    logic          rx_fire;
    logic          word_valid;
    logic [31:0]   word;
    logic [AW-2:0] idx_inc;

    assign RXREADY = (state_q == ST_HDR) || (state_q == ST_DATA) || (state_q == ST_CHK);
    assign rx_fire = RXVALID && RXREADY;
    assign idx_inc = idx_q + IDX_ONE;

    isram_word_packer u_packer (
        .clk_i        (HCLK),
        .rst_ni       (HRESETn),
        .clr_i        (state_d != state_q),
        .byte_valid_i (rx_fire),
        .byte_i       (RXDATA),
        .word_valid_o (word_valid),
        .word_o       (word)
    );

    always_comb begin
        state_d   = state_q;
        n_d       = n_q;
        idx_d     = idx_q;
        sum_d     = sum_q;
        wr_cs_d   = 1'b0;
        wr_wen_d  = 4'h0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;

        unique case (state_q)
            ST_START: state_d = BOOTMODE ? ST_HDR : ST_DONE;
            ST_HDR: begin
                if (word_valid) begin
                    idx_d = '0;
                    sum_d = '0;
                    n_d   = word[AW-2:0];
                    if (word > MAX_WORDS)  state_d = ST_ERROR;
                    else if (word == '0)   state_d = ST_CHK;
                    else                   state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (word_valid) begin
                    wr_cs_d   = 1'b1;
                    wr_wen_d  = 4'hF;
                    wr_addr_d = idx_q[AW-3:0];
                    wr_data_d = word;
                    sum_d     = sum_q + word;
                    idx_d     = idx_inc;
                    if (idx_inc == n_q) state_d = ST_CHK;
                end
            end
            ST_CHK: begin
                if (word_valid) state_d = (word == sum_q) ? ST_DONE : ST_ERROR;
            end
            ST_DONE:  state_d = ST_DONE;
            ST_ERROR: state_d = ST_ERROR;
            default:  state_d = ST_ERROR;
        endcase
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q   <= ST_START;
            n_q       <= '0;
            idx_q     <= '0;
            sum_q     <= '0;
            wr_cs_q   <= 1'b0;
            wr_wen_q  <= 4'h0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            state_q   <= state_d;
            n_q       <= n_d;
            idx_q     <= idx_d;
            sum_q     <= sum_d;
            wr_cs_q   <= wr_cs_d;
            wr_wen_q  <= wr_wen_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    // Port ownership: loader write stage until DONE, then bridge pass-through.
    always_comb begin
        SRAMCS    = wr_cs_q;
        SRAMWEN   = wr_wen_q;
        SRAMADDR  = wr_addr_q;
        SRAMWDATA = wr_data_q;
        if (state_q == ST_DONE) begin
            SRAMCS    = BUS_SRAMCS;
            SRAMWEN   = BUS_SRAMWEN;
            SRAMADDR  = BUS_SRAMADDR;
            SRAMWDATA = BUS_SRAMWDATA;
        end else if (state_q == ST_ERROR) begin
            SRAMCS  = 1'b0;
            SRAMWEN = 4'h0;
        end
    end

    assign CPURESETn = (state_q == ST_DONE);
    assign LOAD_DONE = (state_q == ST_DONE);
    assign LOAD_ERR  = (state_q == ST_ERROR);

endmodule

// File: tb/tb_isram_boot_loader.sv
module tb_isram_boot_loader;

    localparam int AW = 16;

    logic          HCLK, HRESETn, BOOTMODE;
    logic [7:0]    RXDATA;
    logic          RXVALID, RXREADY;
    logic [AW-3:0] BUS_SRAMADDR, SRAMADDR;
    logic [3:0]    BUS_SRAMWEN, SRAMWEN;
    logic [31:0]   BUS_SRAMWDATA, SRAMWDATA;
    logic          BUS_SRAMCS, SRAMCS;
    logic          CPURESETn, LOAD_DONE, LOAD_ERR;

    isram_boot_loader #(.AW(AW)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .BOOTMODE(BOOTMODE),
        .RXDATA(RXDATA), .RXVALID(RXVALID), .RXREADY(RXREADY),
        .BUS_SRAMADDR(BUS_SRAMADDR), .BUS_SRAMWEN(BUS_SRAMWEN),
        .BUS_SRAMWDATA(BUS_SRAMWDATA), .BUS_SRAMCS(BUS_SRAMCS),
        .SRAMADDR(SRAMADDR), .SRAMWEN(SRAMWEN), .SRAMWDATA(SRAMWDATA),
        .SRAMCS(SRAMCS), .CPURESETn(CPURESETn), .LOAD_DONE(LOAD_DONE),
        .LOAD_ERR(LOAD_ERR)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    int total = 0;
    int bad   = 0;

    // SRAM write log, sampled on the falling edge
    bit          mon_en = 1'b0;
    logic [31:0] wq_addr[$];
    logic [31:0] wq_data[$];
    logic [31:0] wq_wen[$];

    always @(negedge HCLK) begin
        if (mon_en && SRAMCS) begin
            wq_addr.push_back(32'(SRAMADDR));
            wq_data.push_back(SRAMWDATA);
            wq_wen.push_back(32'(SRAMWEN));
        end
    end

    typedef struct {
        logic [31:0] n;
        logic [31:0] w0;
        logic [31:0] w1;
        logic [31:0] chk;
        int          gap;
        bit          exp_done;
        bit          exp_err;
        int          exp_nwr;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge HCLK);
        #1;
    endtask

    task automatic reset_dut(input logic bm);
        HRESETn = 1'b0;
        BOOTMODE = bm;
        RXVALID = 1'b0;
        repeat (2) step();
        HRESETn = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int t;
        RXVALID = 1'b0;
        repeat (gap > 0 ? $urandom_range(0, gap) : 0) step();
        RXVALID = 1'b1;
        RXDATA  = b;
        t = 0;
        while (!RXREADY && t < 20) begin
            step();
            t++;
        end
        if (!RXREADY) begin
            check("rxready_timeout", 32'(RXREADY), 32'd1);
            RXVALID = 1'b0;
            return;
        end
        step();
        RXVALID = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input int gap);
        for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], gap);
    endtask

    task automatic load_image(input vec_t v);
        logic [31:0] words[2];
        int nsend;
        words[0] = v.w0;
        words[1] = v.w1;
        send_word(v.n, v.gap);
        if (v.n <= 32'h4000) begin
            nsend = (v.n > 2) ? 2 : int'(v.n);
            for (int i = 0; i < nsend; i++) send_word(words[i], v.gap);
            send_word(v.chk, v.gap);
        end
    endtask

    task automatic check_writes(input vec_t v);
        logic [31:0] words[2];
        int m;
        words[0] = v.w0;
        words[1] = v.w1;
        check("write_count", 32'(wq_addr.size()), 32'(v.exp_nwr));
        m = (wq_addr.size() < v.exp_nwr) ? wq_addr.size() : v.exp_nwr;
        for (int i = 0; i < m; i++) begin
            check("write_addr", wq_addr[i], 32'(i));
            check("write_data", wq_data[i], words[i]);
            check("write_wen", wq_wen[i], 32'hF);
        end
    endtask

    initial begin
        vec_t mid;
        HRESETn = 1'b0; BOOTMODE = 1'b0; RXDATA = '0; RXVALID = 1'b0;
        BUS_SRAMADDR = '0; BUS_SRAMWEN = '0; BUS_SRAMWDATA = '0; BUS_SRAMCS = 1'b0;

        vecs[0] = '{32'd2, 32'h11223344, 32'hA5A5A5A5, 32'hB6C7D8E9, 0, 1, 0, 2};
        vecs[1] = '{32'd2, 32'h11223344, 32'hA5A5A5A5, 32'hB6C7D8EA, 0, 0, 1, 2};
        vecs[2] = '{32'd0, 32'h0,        32'h0,        32'h00000000, 0, 1, 0, 0};
        vecs[3] = '{32'h4001, 32'h0,     32'h0,        32'h00000000, 0, 0, 1, 0};
        vecs[4] = '{32'd2, 32'h11223344, 32'hA5A5A5A5, 32'hB6C7D8E9, 7, 1, 0, 2};
        vecs[5] = '{32'd1, 32'hDEADBEEF, 32'h0,        32'hDEADBEEF, 3, 1, 0, 1};
        vecs[6] = '{32'd0, 32'h0,        32'h0,        32'h00000001, 0, 0, 1, 0};

        // Reset values and BOOTMODE=0 bypass
        BUS_SRAMCS = 1'b1; BUS_SRAMADDR = 14'd5; BUS_SRAMWEN = 4'h3; BUS_SRAMWDATA = 32'h12345678;
        HRESETn = 1'b0;
        repeat (2) step();
        check("rst_rxready", 32'(RXREADY), 0);
        check("rst_sramcs", 32'(SRAMCS), 0);
        check("rst_sramwen", 32'(SRAMWEN), 0);
        check("rst_sramaddr", 32'(SRAMADDR), 0);
        check("rst_sramwdata", SRAMWDATA, 0);
        check("rst_cpureset", 32'(CPURESETn), 0);
        check("rst_done", 32'(LOAD_DONE), 0);
        check("rst_err", 32'(LOAD_ERR), 0);
        HRESETn = 1'b1;
        RXVALID = 1'b1; RXDATA = 8'h55;
        check("bypass_c0_done", 32'(LOAD_DONE), 0);
        for (int c = 1; c <= 4; c++) begin
            step();
            check("bypass_rxready", 32'(RXREADY), 0);
            if (c == 2) begin
                check("bypass_done", 32'(LOAD_DONE), 1);
                check("bypass_cpureset", 32'(CPURESETn), 1);
                check("bypass_cs", 32'(SRAMCS), 1);
                check("bypass_addr", 32'(SRAMADDR), 5);
                check("bypass_wen", 32'(SRAMWEN), 32'h3);
                check("bypass_wdata", SRAMWDATA, 32'h12345678);
            end
        end
        RXVALID = 1'b0;
        BUS_SRAMCS = 1'b0; BUS_SRAMWEN = 4'h0;

        // Table-driven image loads
        for (int v = 0; v < 7; v++) begin
            reset_dut(1'b1);
            wq_addr.delete(); wq_data.delete(); wq_wen.delete();
            mon_en = 1'b1;
            load_image(vecs[v]);
            // status must be visible right after the final accepted byte
            check("vec_done", 32'(LOAD_DONE), 32'(vecs[v].exp_done));
            check("vec_err", 32'(LOAD_ERR), 32'(vecs[v].exp_err));
            check("vec_cpureset", 32'(CPURESETn), 32'(vecs[v].exp_done));
            step();
            mon_en = 1'b0;
            check_writes(vecs[v]);
            BUS_SRAMCS = 1'b1; BUS_SRAMWEN = 4'hF; BUS_SRAMADDR = 14'd5; BUS_SRAMWDATA = 32'hCAFEF00D;
            #1;
            check("vec_fwd_cs", 32'(SRAMCS), 32'(vecs[v].exp_done));
            check("vec_fwd_wen", 32'(SRAMWEN), vecs[v].exp_done ? 32'hF : 32'h0);
            BUS_SRAMCS = 1'b0; BUS_SRAMWEN = 4'h0;
        end

        // Reset in the middle of a load, then a complete reload
        mid = vecs[0];
        reset_dut(1'b1);
        send_word(mid.n, 0);
        send_word(mid.w0, 0);
        check("mid_wr_cs", 32'(SRAMCS), 1);
        check("mid_wr_addr", 32'(SRAMADDR), 0);
        check("mid_wr_data", SRAMWDATA, 32'h11223344);
        step();
        check("mid_wr_pulse", 32'(SRAMCS), 0);
        #1;
        HRESETn = 1'b0;
        #1;
        check("mid_rst_cs", 32'(SRAMCS), 0);
        check("mid_rst_wen", 32'(SRAMWEN), 0);
        check("mid_rst_addr", 32'(SRAMADDR), 0);
        check("mid_rst_wdata", SRAMWDATA, 0);
        check("mid_rst_cpureset", 32'(CPURESETn), 0);
        check("mid_rst_rxready", 32'(RXREADY), 0);
        reset_dut(1'b1);
        wq_addr.delete(); wq_data.delete(); wq_wen.delete();
        mon_en = 1'b1;
        load_image(mid);
        check("reload_done", 32'(LOAD_DONE), 1);
        check("reload_cpureset", 32'(CPURESETn), 1);
        step();
        mon_en = 1'b0;
        check_writes(mid);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
